// File: rtl/eim_bridge_pkg.sv
// Shared types and constants for the EIM-to-register bridge.
//   eim_state_t        : bridge FSM states
//   WR_HOLD_DEFAULT    : default cycles reg_data_index stays high per write
//   RD_TIMEOUT_DEFAULT : default cycles to wait for read_data_en
//   BUS_ERR_MAX        : saturation value of bus_err_cnt
package eim_bridge_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StAddr,
        StWrHold,
        StRdWait,
        StRdDrive,
        StDone
    } eim_state_t;

    localparam int unsigned WR_HOLD_DEFAULT    = 2;
    localparam int unsigned RD_TIMEOUT_DEFAULT = 8;
    localparam logic [7:0]  BUS_ERR_MAX        = 8'hFF;

endpackage

// File: rtl/eim_sync.sv
// Two-flop synchroniser for a bundle of asynchronous inputs.
//   eim_clk    : destination clock
//   eim_rst    : synchronous active-high reset, loads ResetVal into both stages
//   data_async : asynchronous inputs
//   data_sync  : synchronised outputs (second flop stage)
module eim_sync #(
    parameter int unsigned      Width    = 1,
    parameter logic [Width-1:0] ResetVal = '0
) (
    input  logic             eim_clk,
    input  logic             eim_rst,
    input  logic [Width-1:0] data_async,
    output logic [Width-1:0] data_sync
);

    logic [Width-1:0] meta_q;
    logic [Width-1:0] sync_q;

    always_ff @(posedge eim_clk) begin
        if (eim_rst) begin
            meta_q <= ResetVal;
            sync_q <= ResetVal;
        end else begin
            meta_q <= data_async;
            sync_q <= meta_q;
        end
    end

    assign data_sync = sync_q;

endmodule

// File: rtl/eim_reg_bridge.sv
// Bridge from the asynchronous i.MX EIM multiplexed AD bus to the reg_map strobe protocol.
//   eim_clk, eim_rst                      : bridge clock, synchronous active-high reset
//   eim_cs_n/adv_n/we_n/oe_n, eim_ad_in   : asynchronous EIM pins
//   eim_ad_out, eim_ad_oe, eim_wait_n     : read data, pad enable and WAIT back to the host
//   reg_addr, reg_data                    : captured address / write data
//   reg_addr_index, reg_data_index        : address-valid and write-commit strobes
//   reg_read_index                        : read request strobe
//   reg_read_out, read_data_en            : read data and its valid from reg_map
//   bus_err_cnt                           : saturating count of read timeouts and protocol errors
// All outputs are registered from the current state, so strobes lag the state by one cycle.
module eim_reg_bridge
    import eim_bridge_pkg::*;
#(
    parameter int unsigned WR_HOLD    = WR_HOLD_DEFAULT,
    parameter int unsigned RD_TIMEOUT = RD_TIMEOUT_DEFAULT
) (
    input  logic        eim_clk,
    input  logic        eim_rst,
    input  logic        eim_cs_n,
    input  logic        eim_adv_n,
    input  logic        eim_we_n,
    input  logic        eim_oe_n,
    input  logic [15:0] eim_ad_in,
    output logic [15:0] eim_ad_out,
    output logic        eim_ad_oe,
    output logic        eim_wait_n,
    output logic [15:0] reg_addr,
    output logic [15:0] reg_data,
    output logic        reg_addr_index,
    output logic        reg_data_index,
    output logic        reg_read_index,
    input  logic [15:0] reg_read_out,
    input  logic        read_data_en,
    output logic [7:0]  bus_err_cnt
);

    localparam int unsigned CntW = 16;

    // ---------------------------------------------------------------- synchronisation
    logic [19:0] pins_async;
    logic [19:0] pins_sync;
    logic        cs_s, adv_s, we_s, oe_s;
    logic [15:0] ad_s;

    assign pins_async = {eim_cs_n, eim_adv_n, eim_we_n, eim_oe_n, eim_ad_in};

    // Active-low controls reset to their idle (high) level so reset never looks like a cycle.
    eim_sync #(
        .Width    (20),
        .ResetVal (20'hF_0000)
    ) u_sync (
        .eim_clk    (eim_clk),
        .eim_rst    (eim_rst),
        .data_async (pins_async),
        .data_sync  (pins_sync)
    );

    assign {cs_s, adv_s, we_s, oe_s, ad_s} = pins_sync;

    // Third copy of we_n for edge detection; the edge itself is registered once more.
    logic we_d3_q;
    logic we_rise_now;
    logic we_rise_q;

    assign we_rise_now = we_s & ~we_d3_q;

    always_ff @(posedge eim_clk) begin
        if (eim_rst) begin
            we_d3_q   <= 1'b1;
            we_rise_q <= 1'b0;
        end else begin
            we_d3_q   <= we_s;
            we_rise_q <= we_rise_now;
        end
    end

    // ---------------------------------------------------------------- FSM state register
    eim_state_t      state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    always_ff @(posedge eim_clk) begin
        if (eim_rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // ---------------------------------------------------------------- next state
    logic addr_go, wr_go, rd_release, rd_timeout, proto_err;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_go    = 1'b0;
        wr_go      = 1'b0;
        rd_release = 1'b0;
        rd_timeout = 1'b0;
        proto_err  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!cs_s && !adv_s) begin
                    addr_go = 1'b1;
                    state_d = StAddr;
                end
            end
            StAddr: begin
                if (!we_s && !oe_s) begin
                    proto_err = 1'b1;
                    state_d   = StDone;
                end else if (we_rise_q && oe_s) begin
                    wr_go   = 1'b1;
                    cnt_d   = '0;
                    state_d = StWrHold;
                end else if (!oe_s && we_s) begin
                    cnt_d   = '0;
                    state_d = StRdWait;
                end else if (cs_s && !we_rise_now && !we_rise_q) begin
                    // A we_n edge still in the pipeline means CS rose with WE; keep the write.
                    state_d = StIdle;
                end
            end
            StWrHold: begin
                if (cnt_q == CntW'(WR_HOLD - 1)) begin
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StRdWait: begin
                // Valid data wins over a timeout landing in the same cycle.
                if (read_data_en) begin
                    rd_release = 1'b1;
                    state_d    = StRdDrive;
                end else if (cnt_q == CntW'(RD_TIMEOUT - 1)) begin
                    rd_release = 1'b1;
                    rd_timeout = 1'b1;
                    state_d    = StRdDrive;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StRdDrive: begin
                if (oe_s || cs_s) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (cs_s) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // ---------------------------------------------------------------- outputs
    logic [15:0] reg_addr_q, reg_addr_d;
    logic [15:0] reg_data_q, reg_data_d;
    logic [15:0] ad_out_q, ad_out_d;
    logic        addr_index_q, addr_index_d;
    logic        data_index_q, data_index_d;
    logic        read_index_q, read_index_d;
    logic        ad_oe_q, ad_oe_d;
    logic        wait_n_q, wait_n_d;
    logic [7:0]  err_cnt_q, err_cnt_d;

    always_comb begin
        reg_addr_d   = addr_go ? ad_s : reg_addr_q;
        reg_data_d   = wr_go ? ad_s : reg_data_q;
        ad_out_d     = rd_release ? reg_read_out : ad_out_q;
        addr_index_d = (state_q == StAddr) || (state_q == StWrHold) ||
                       (state_q == StRdWait) || (state_q == StRdDrive);
        data_index_d = (state_q == StWrHold);
        read_index_d = (state_q == StRdWait) || (state_q == StRdDrive);
        ad_oe_d      = (state_q == StRdDrive);
        wait_n_d     = (state_q != StRdWait);
        err_cnt_d    = err_cnt_q;
        if ((proto_err || rd_timeout) && (err_cnt_q != BUS_ERR_MAX)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge eim_clk) begin
        if (eim_rst) begin
            reg_addr_q   <= '0;
            reg_data_q   <= '0;
            ad_out_q     <= '0;
            addr_index_q <= 1'b0;
            data_index_q <= 1'b0;
            read_index_q <= 1'b0;
            ad_oe_q      <= 1'b0;
            wait_n_q     <= 1'b1;
            err_cnt_q    <= '0;
        end else begin
            reg_addr_q   <= reg_addr_d;
            reg_data_q   <= reg_data_d;
            ad_out_q     <= ad_out_d;
            addr_index_q <= addr_index_d;
            data_index_q <= data_index_d;
            read_index_q <= read_index_d;
            ad_oe_q      <= ad_oe_d;
            wait_n_q     <= wait_n_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    assign reg_addr       = reg_addr_q;
    assign reg_data       = reg_data_q;
    assign eim_ad_out     = ad_out_q;
    assign reg_addr_index = addr_index_q;
    assign reg_data_index = data_index_q;
    assign reg_read_index = read_index_q;
    assign eim_ad_oe      = ad_oe_q;
    assign eim_wait_n     = wait_n_q;
    assign bus_err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_eim_reg_bridge.sv
// Scoreboard bench for eim_reg_bridge: host tasks drive EIM cycles and push the expected
// transaction; a monitor frames each reg_addr_index window and compares against the queue.
module tb_eim_reg_bridge;

    localparam int WrHold    = 2;
    localparam int RdTimeout = 8;
    localparam int KWr = 0;
    localparam int KRd = 1;
    localparam int KAd = 2;

    logic        eim_clk = 1'b0;
    logic        eim_rst;
    logic        eim_cs_n, eim_adv_n, eim_we_n, eim_oe_n;
    logic [15:0] eim_ad_in;
    logic [15:0] eim_ad_out;
    logic        eim_ad_oe, eim_wait_n;
    logic [15:0] reg_addr, reg_data;
    logic        reg_addr_index, reg_data_index, reg_read_index;
    logic [15:0] reg_read_out;
    logic        read_data_en;
    logic [7:0]  bus_err_cnt;

    always #5 eim_clk = ~eim_clk;

    eim_reg_bridge #(
        .WR_HOLD    (WrHold),
        .RD_TIMEOUT (RdTimeout)
    ) dut (
        .eim_clk        (eim_clk),
        .eim_rst        (eim_rst),
        .eim_cs_n       (eim_cs_n),
        .eim_adv_n      (eim_adv_n),
        .eim_we_n       (eim_we_n),
        .eim_oe_n       (eim_oe_n),
        .eim_ad_in      (eim_ad_in),
        .eim_ad_out     (eim_ad_out),
        .eim_ad_oe      (eim_ad_oe),
        .eim_wait_n     (eim_wait_n),
        .reg_addr       (reg_addr),
        .reg_data       (reg_data),
        .reg_addr_index (reg_addr_index),
        .reg_data_index (reg_data_index),
        .reg_read_index (reg_read_index),
        .reg_read_out   (reg_read_out),
        .read_data_en   (read_data_en),
        .bus_err_cnt    (bus_err_cnt)
    );

    typedef struct {
        int          kind;
        logic [15:0] addr;
        logic [15:0] data;
        int          wait_c;
        logic [7:0]  err;
    } exp_t;

    exp_t        exp_q[$];
    int          n_cmp = 0;
    int          n_mis = 0;
    logic [15:0] mem [16];
    logic [7:0]  model_err = 8'd0;
    int          rsp_lat = 0;

    // reg_map stand-in: combinational read port over the model memory
    assign reg_read_out = mem[reg_addr[3:0]];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge eim_clk);
        #2;
    endtask

    function automatic void bump_err();
        if (model_err != 8'hFF) model_err = model_err + 8'd1;
    endfunction

    // ------------------------------------------------------------ host bus tasks
    task automatic addr_phase(input logic [15:0] a);
        eim_cs_n = 1'b0; eim_adv_n = 1'b0; eim_ad_in = a;
        cyc(4);
        eim_adv_n = 1'b1;
    endtask

    task automatic host_write(input logic [15:0] a, input logic [15:0] d, input bit early_cs);
        exp_t e;
        e = '{kind: KWr, addr: a, data: d, wait_c: 0, err: model_err};
        exp_q.push_back(e);
        mem[a[3:0]] = d;
        addr_phase(a);
        eim_ad_in = d; eim_we_n = 1'b0;
        cyc(3);
        eim_we_n = 1'b1;
        if (early_cs) eim_cs_n = 1'b1;
        cyc(6);
        eim_cs_n = 1'b1;
        cyc(6);
    endtask

    // lat = cycles from reg_read_index to read_data_en sample; 0 = never answer
    task automatic host_read(input logic [15:0] a, input int lat);
        exp_t e;
        int   n;
        bit   valid;
        valid = (lat != 0) && (lat <= RdTimeout - 1);
        if (!valid) bump_err();
        e = '{kind: KRd, addr: a, data: mem[a[3:0]],
              wait_c: (valid ? lat + 1 : RdTimeout), err: model_err};
        exp_q.push_back(e);
        rsp_lat = lat;
        addr_phase(a);
        eim_oe_n = 1'b0;
        n = 0;
        while (eim_ad_oe !== 1'b1 && n < 40) begin
            cyc(1);
            n++;
        end
        if (eim_ad_oe !== 1'b1) begin
            n_cmp++; n_mis++;
            $display("FAIL read_release: eim_ad_oe=%b, required 1 within 40 cycles", eim_ad_oe);
        end
        cyc(2);
        eim_oe_n = 1'b1;
        cyc(2);
        eim_cs_n = 1'b1;
        cyc(6);
    endtask

    task automatic host_addr_only(input logic [15:0] a);
        exp_t e;
        e = '{kind: KAd, addr: a, data: 16'h0, wait_c: 0, err: model_err};
        exp_q.push_back(e);
        addr_phase(a);
        cyc(2);
        eim_cs_n = 1'b1;
        cyc(6);
    endtask

    task automatic host_proto_err(input logic [15:0] a);
        exp_t e;
        bump_err();
        e = '{kind: KAd, addr: a, data: 16'h0, wait_c: 0, err: model_err};
        exp_q.push_back(e);
        addr_phase(a);
        eim_we_n = 1'b0; eim_oe_n = 1'b0;
        cyc(4);
        eim_we_n = 1'b1; eim_oe_n = 1'b1; eim_cs_n = 1'b1;
        cyc(6);
    endtask

    // ------------------------------------------------------------ reg_map read responder
    initial begin
        bit seen;
        seen = 1'b0;
        read_data_en = 1'b0;
        forever begin
            @(negedge eim_clk);
            if (reg_read_index && !seen) begin
                seen = 1'b1;
                if (rsp_lat != 0) begin
                    repeat (rsp_lat - 1) @(negedge eim_clk);
                    read_data_en = 1'b1;
                    @(negedge eim_clk);
                    read_data_en = 1'b0;
                end
            end else if (!reg_read_index) begin
                seen = 1'b0;
            end
        end
    end

    // ------------------------------------------------------------ monitor
    int stray = 0;

    initial begin
        bit          in_win, saw_wr, saw_rd, rd_done, overlap;
        int          wr_width, wait_c;
        logic [15:0] w_addr, w_data;
        logic        w_oe;
        int          kind;
        exp_t        e;
        in_win = 1'b0;
        forever begin
            @(negedge eim_clk);
            if (eim_rst) begin
                in_win = 1'b0;
            end else if (reg_addr_index) begin
                if (!in_win) begin
                    in_win = 1'b1; saw_wr = 1'b0; saw_rd = 1'b0; rd_done = 1'b0;
                    overlap = 1'b0; wr_width = 0; wait_c = 0;
                    w_addr = reg_addr; w_data = 16'h0; w_oe = 1'b0;
                end
                if (reg_data_index) begin
                    saw_wr = 1'b1;
                    wr_width++;
                    if (wr_width == 1) w_data = reg_data;
                end
                if (reg_read_index) begin
                    saw_rd = 1'b1;
                    if (!eim_wait_n) begin
                        wait_c++;
                    end else if (!rd_done) begin
                        rd_done = 1'b1;
                        w_data = eim_ad_out;
                        w_oe = eim_ad_oe;
                    end
                end
                if (reg_data_index && reg_read_index) overlap = 1'b1;
            end else begin
                if (reg_data_index || reg_read_index) stray++;
                if (in_win) begin
                    in_win = 1'b0;
                    kind = saw_wr ? KWr : (saw_rd ? KRd : KAd);
                    if (exp_q.size() == 0) begin
                        n_cmp++; n_mis++;
                        $display("FAIL unexpected_txn: got kind %0d addr 0x%0h, required none",
                                 kind, w_addr);
                    end else begin
                        e = exp_q.pop_front();
                        chk("txn_kind", kind, e.kind);
                        chk("txn_addr", w_addr, e.addr);
                        chk("txn_err_cnt", bus_err_cnt, e.err);
                        chk("strobe_overlap", overlap, 0);
                        if (e.kind == KWr) begin
                            chk("wr_data", w_data, e.data);
                            chk("wr_strobe_width", wr_width, WrHold);
                        end
                        if (e.kind == KRd) begin
                            chk("rd_data", w_data, e.data);
                            chk("rd_wait_cycles", wait_c, e.wait_c);
                            chk("rd_ad_oe", w_oe, 1);
                        end
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running, required completion");
        $fatal(1);
    end

    // ------------------------------------------------------------ stimulus
    initial begin
        int n;
        for (int i = 0; i < 16; i++) mem[i] = 16'($urandom);
        eim_rst = 1'b1;
        eim_cs_n = 1'b1; eim_adv_n = 1'b1; eim_we_n = 1'b1; eim_oe_n = 1'b1;
        eim_ad_in = 16'h0;
        cyc(3);
        chk("rst_reg_addr", reg_addr, 16'h0);
        chk("rst_reg_data", reg_data, 16'h0);
        chk("rst_ad_out", eim_ad_out, 16'h0);
        chk("rst_strobes", {reg_addr_index, reg_data_index, reg_read_index}, 3'b000);
        chk("rst_ad_oe", eim_ad_oe, 1'b0);
        chk("rst_wait_n", eim_wait_n, 1'b1);
        chk("rst_err_cnt", bus_err_cnt, 8'h00);
        eim_rst = 1'b0;
        cyc(4);

        host_write(16'h0003, 16'hABCD, 1'b0);
        host_read(16'h0003, 3);
        host_read(16'h0003, 0);
        host_addr_only(16'h0005);
        host_proto_err(16'h0002);
        host_write(16'h0001, 16'h1234, 1'b0);
        host_read(16'h0001, RdTimeout - 1);
        host_write(16'h0007, 16'h5A5A, 1'b1);
        host_read(16'h0007, RdTimeout);

        // reset while waiting for read data
        rsp_lat = 0;
        addr_phase(16'h0004);
        eim_oe_n = 1'b0;
        n = 0;
        while (reg_read_index !== 1'b1 && n < 20) begin
            cyc(1);
            n++;
        end
        chk("rst_test_read_started", reg_read_index, 1'b1);
        cyc(2);
        eim_rst = 1'b1;
        @(posedge eim_clk);
        #1;
        chk("midrst_strobes", {reg_addr_index, reg_data_index, reg_read_index}, 3'b000);
        chk("midrst_ad_oe", eim_ad_oe, 1'b0);
        chk("midrst_wait_n", eim_wait_n, 1'b1);
        chk("midrst_err_cnt", bus_err_cnt, 8'h00);
        model_err = 8'd0;
        eim_cs_n = 1'b1; eim_oe_n = 1'b1;
        cyc(1);
        eim_rst = 1'b0;
        cyc(4);

        for (int i = 0; i < 40; i++) begin
            logic [15:0] a;
            a = 16'($urandom_range(0, 15));
            case ($urandom_range(0, 4))
                0, 1: host_write(a, 16'($urandom), 1'($urandom_range(0, 1)));
                2: host_read(a, $urandom_range(0, 10));
                3: host_addr_only(a);
                default: host_proto_err(a);
            endcase
        end

        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            cyc(1);
            n++;
        end
        chk("scoreboard_drained", exp_q.size(), 0);
        chk("stray_strobes", stray, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
